// File: rtl/latch_seq_pkg.sv
// Shared definitions for the latch write sequencer: one-hot state encoding,
// error-counter width and a small elaboration-time helper.
package latch_seq_pkg;

    localparam int ERR_CNT_W = 8;

    localparam int IDLE_B  = 0;
    localparam int SETUP_B = 1;
    localparam int PULSE_B = 2;
    localparam int HOLD_B  = 3;
    localparam int CHECK_B = 4;

    // One flop per state so outputs like lat_en come straight off a single flop.
    typedef enum logic [4:0] {
        IDLE  = 5'b00001,
        SETUP = 5'b00010,
        PULSE = 5'b00100,
        HOLD  = 5'b01000,
        CHECK = 5'b10000
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/cyc_timer.sv
// Down-counter shared by the setup, pulse and hold windows: load a count,
// decrement once per cycle, report when it has reached zero.
module cyc_timer #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_sequencer.sv
// Drives a transparent-latch bank with programmable setup / pulse / hold windows,
// reads the latch back after each write and counts mismatches.
module latch_write_sequencer
    import latch_seq_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 in_ready,
    output logic [WIDTH-1:0]     lat_d,
    output logic                 lat_en,
    input  logic [WIDTH-1:0]     lat_q,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [ERR_CNT_W-1:0] err_count
);

    localparam int MAX_CYC = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    if (SETUP_CYC < 1 || PULSE_CYC < 1 || HOLD_CYC < 1) begin : g_param_check
        $error("latch_write_sequencer: SETUP_CYC, PULSE_CYC and HOLD_CYC must all be >= 1");
    end

    state_t           state;
    state_t           next_state;
    logic             accept;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_dec;
    logic             tmr_zero;

    cyc_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .dec      (tmr_dec),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Each window reloads the timer for the next one on its final cycle.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_dec    = 1'b0;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    accept     = 1'b1;
                    tmr_load   = 1'b1;
                    tmr_val    = SETUP_LD;
                    next_state = SETUP;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    tmr_load   = 1'b1;
                    tmr_val    = PULSE_LD;
                    next_state = PULSE;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            PULSE: begin
                if (tmr_zero) begin
                    tmr_load   = 1'b1;
                    tmr_val    = HOLD_LD;
                    next_state = HOLD;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            HOLD: begin
                if (tmr_zero) begin
                    next_state = CHECK;
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            CHECK: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_d <= '0;
        end else if (accept) begin
            lat_d <= in_data;
        end
    end

    // Saturates rather than wrapping so a long-failing bank still reads as "many errors".
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err && (err_count != '1)) begin
            err_count <= err_count + ERR_CNT_W'(1);
        end
    end

    assign in_ready = state[IDLE_B];
    assign busy     = ~state[IDLE_B];
    assign lat_en   = state[PULSE_B];
    assign done     = state[CHECK_B];
    assign err      = state[CHECK_B] && (lat_q != lat_d);

endmodule

// File: tb/tb_latch_write_sequencer.sv
// Bench for latch_write_sequencer: default and re-parameterised instances, each
// driving a behavioural D-latch, checked cycle by cycle against window arithmetic.
module tb_latch_write_sequencer;

    localparam int S1 = 1, P1 = 2, H1 = 1, T1 = S1 + P1 + H1 + 2;
    localparam int S2 = 3, P2 = 4, H2 = 2, T2 = S2 + P2 + H2 + 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sel;
    logic       stuck;

    logic       in_valid1, in_ready1, lat_en1, busy1, done1, err1;
    logic [7:0] in_data1, lat_d1, lat_q1, err_count1, cap1;
    logic       in_valid2, in_ready2, lat_en2, busy2, done2, err2;
    logic [7:0] in_data2, lat_d2, lat_q2, err_count2, cap2;

    logic [4:0] mon_ctl;
    logic [7:0] mon_d, mon_cnt;
    logic [4:0] obs_ctl [1:T2];
    logic [7:0] obs_d   [1:T2];
    logic [7:0] obs_cnt [1:T2];

    int tests_run    = 0;
    int tests_failed = 0;
    int model_cnt1   = 0;
    int model_cnt2   = 0;

    always #5 clk = ~clk;

    latch_write_sequencer u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_data(in_data1),
        .in_ready(in_ready1), .lat_d(lat_d1), .lat_en(lat_en1), .lat_q(lat_q1),
        .busy(busy1), .done(done1), .err(err1), .err_count(err_count1)
    );

    latch_write_sequencer #(.WIDTH(8), .SETUP_CYC(S2), .PULSE_CYC(P2), .HOLD_CYC(H2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_data(in_data2),
        .in_ready(in_ready2), .lat_d(lat_d2), .lat_en(lat_en2), .lat_q(lat_q2),
        .busy(busy2), .done(done2), .err(err2), .err_count(err_count2)
    );

    // Behavioural transparent latches; "stuck" models a bank whose outputs read zero.
    always_latch if (lat_en1) cap1 <= lat_d1;
    always_latch if (lat_en2) cap2 <= lat_d2;
    assign lat_q1 = stuck ? 8'h00 : cap1;
    assign lat_q2 = stuck ? 8'h00 : cap2;

    assign mon_ctl = sel ? {in_ready2, busy2, lat_en2, done2, err2}
                         : {in_ready1, busy1, lat_en1, done1, err1};
    assign mon_d   = sel ? lat_d2 : lat_d1;
    assign mon_cnt = sel ? err_count2 : err_count1;

    // Expected {in_ready, busy, lat_en, done, err} in cycle n after an accept.
    function automatic logic [4:0] exp_ctl(input int n, input int s, input int p, input int h,
                                           input logic mism);
        logic rdy, dn, en;
        rdy = (n == s + p + h + 2);
        dn  = (n == s + p + h + 1);
        en  = (n > s) && (n <= s + p);
        return {rdy, ~rdy, en, dn, dn & mism};
    endfunction

    function automatic int sat_inc(input int c, input logic mism);
        return (mism && c < 255) ? c + 1 : c;
    endfunction

    task automatic set_valid(input logic v, input logic [7:0] d);
        if (sel) begin
            in_valid2 = v;
            in_data2  = d;
        end else begin
            in_valid1 = v;
            in_data1  = d;
        end
    endtask

    // Presents one word from an idle negedge and records outputs until the next idle cycle.
    task automatic capture(input logic [7:0] data, input logic hold_valid);
        int t;
        t = sel ? T2 : T1;
        set_valid(1'b1, data);
        @(posedge clk);
        for (int n = 1; n <= t; n++) begin
            @(negedge clk);
            obs_ctl[n] = mon_ctl;
            obs_d[n]   = mon_d;
            obs_cnt[n] = mon_cnt;
            if (n < t) set_valid(hold_valid, 8'($urandom));
            else       set_valid(1'b0, 8'($urandom));
        end
    endtask

    task automatic test_reset();
        sel = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({in_ready1, busy1, lat_en1, done1, err1, lat_d1, err_count1} !== {5'b10000, 8'h00, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL reset_values: got ctl=%b lat_d=%h cnt=%h expected ctl=10000 lat_d=00 cnt=00",
                     {in_ready1, busy1, lat_en1, done1, err1}, lat_d1, err_count1);
        end
        rst_n = 1'b1;
        model_cnt1 = 0;
        model_cnt2 = 0;
        set_valid(1'b1, 8'hC3);
        @(posedge clk);
        @(negedge clk);
        set_valid(1'b0, 8'h00);
        @(negedge clk);
        tests_run++;
        if (lat_en1 !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_pulse_reached: lat_en got %b expected 1", lat_en1);
        end
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({lat_en1, lat_d1} !== {1'b0, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL reset_async_abort: lat_en/lat_d got %b/%h expected 0/00", lat_en1, lat_d1);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        tests_run++;
        if ({in_ready1, busy1, err_count1, err_count2} !== {1'b1, 1'b0, 8'h00, 8'h00}) begin
            tests_failed++;
            $display("[TB] FAIL reset_release: ready/busy/cnt1/cnt2 got %b/%b/%h/%h expected 1/0/00/00",
                     in_ready1, busy1, err_count1, err_count2);
        end
    endtask

    task automatic test_single_write();
        logic [4:0] e;
        sel = 1'b0;
        stuck = 1'b0;
        capture(8'hA5, 1'b0);
        for (int n = 1; n <= T1; n++) begin
            e = exp_ctl(n, S1, P1, H1, 1'b0);
            tests_run++;
            if ({obs_ctl[n], obs_d[n]} !== {e, 8'hA5}) begin
                tests_failed++;
                $display("[TB] FAIL single cycle %0d: ctl/lat_d got %b/%h expected %b/a5", n, obs_ctl[n], obs_d[n], e);
            end
        end
        tests_run++;
        if (obs_cnt[T1] !== 8'(model_cnt1)) begin
            tests_failed++;
            $display("[TB] FAIL single err_count: got %0d expected %0d", obs_cnt[T1], model_cnt1);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [4:0] e;
        words = '{8'h11, 8'h22, 8'h33};
        sel = 1'b0;
        stuck = 1'b0;
        for (int i = 0; i < 3; i++) begin
            capture(words[i], 1'b1);
            for (int n = 1; n <= T1; n++) begin
                e = exp_ctl(n, S1, P1, H1, 1'b0);
                tests_run++;
                if ({obs_ctl[n], obs_d[n]} !== {e, words[i]}) begin
                    tests_failed++;
                    $display("[TB] FAIL back_to_back word %0d cycle %0d: ctl/lat_d got %b/%h expected %b/%h",
                             i, n, obs_ctl[n], obs_d[n], e, words[i]);
                end
            end
        end
    endtask

    task automatic test_stuck_latch();
        logic [4:0] e;
        sel = 1'b0;
        stuck = 1'b1;
        capture(8'hFF, 1'b0);
        model_cnt1 = sat_inc(model_cnt1, 1'b1);
        for (int n = 1; n <= T1; n++) begin
            e = exp_ctl(n, S1, P1, H1, 1'b1);
            tests_run++;
            if ({obs_ctl[n], obs_d[n]} !== {e, 8'hFF}) begin
                tests_failed++;
                $display("[TB] FAIL stuck cycle %0d: ctl/lat_d got %b/%h expected %b/ff", n, obs_ctl[n], obs_d[n], e);
            end
        end
        tests_run++;
        if (obs_cnt[T1] !== 8'(model_cnt1)) begin
            tests_failed++;
            $display("[TB] FAIL stuck err_count: got %0d expected %0d", obs_cnt[T1], model_cnt1);
        end
        stuck = 1'b0;
    endtask

    task automatic test_saturation();
        logic [7:0] d;
        logic [4:0] e;
        sel = 1'b0;
        stuck = 1'b1;
        for (int i = 0; i < 260; i++) begin
            d = 8'($urandom_range(1, 255));
            capture(d, 1'b0);
            model_cnt1 = sat_inc(model_cnt1, 1'b1);
            e = exp_ctl(S1 + P1 + H1 + 1, S1, P1, H1, 1'b1);
            tests_run++;
            if ({obs_ctl[S1+P1+H1+1], obs_cnt[T1]} !== {e, 8'(model_cnt1)}) begin
                tests_failed++;
                $display("[TB] FAIL saturate write %0d: check-cycle ctl/err_count got %b/%0d expected %b/%0d",
                         i, obs_ctl[S1+P1+H1+1], obs_cnt[T1], e, model_cnt1);
            end
        end
        stuck = 1'b0;
    endtask

    task automatic test_random_writes();
        logic [7:0] d, last_d;
        logic       mism;
        logic [4:0] e;
        int         gap;
        sel = 1'b0;
        last_d = lat_d1;
        for (int i = 0; i < 40; i++) begin
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                set_valid(1'b0, 8'($urandom));
                @(posedge clk);
                @(negedge clk);
                tests_run++;
                if ({in_ready1, lat_d1} !== {1'b1, last_d}) begin
                    tests_failed++;
                    $display("[TB] FAIL random idle hold: ready/lat_d got %b/%h expected 1/%h", in_ready1, lat_d1, last_d);
                end
            end
            d = 8'($urandom);
            stuck = ($urandom_range(0, 3) == 0);
            mism = stuck && (d != 8'h00);
            capture(d, 1'($urandom_range(0, 1)));
            model_cnt1 = sat_inc(model_cnt1, mism);
            last_d = d;
            for (int n = 1; n <= T1; n++) begin
                e = exp_ctl(n, S1, P1, H1, mism);
                tests_run++;
                if ({obs_ctl[n], obs_d[n]} !== {e, d}) begin
                    tests_failed++;
                    $display("[TB] FAIL random write %0d cycle %0d: ctl/lat_d got %b/%h expected %b/%h",
                             i, n, obs_ctl[n], obs_d[n], e, d);
                end
            end
            tests_run++;
            if (obs_cnt[T1] !== 8'(model_cnt1)) begin
                tests_failed++;
                $display("[TB] FAIL random err_count write %0d: got %0d expected %0d", i, obs_cnt[T1], model_cnt1);
            end
        end
        stuck = 1'b0;
    endtask

    task automatic test_reparam();
        logic [7:0] d;
        logic [4:0] e;
        sel = 1'b1;
        stuck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = (i == 0) ? 8'h5A : 8'($urandom);
            capture(d, 1'b1);
            for (int n = 1; n <= T2; n++) begin
                e = exp_ctl(n, S2, P2, H2, 1'b0);
                tests_run++;
                if ({obs_ctl[n], obs_d[n]} !== {e, d}) begin
                    tests_failed++;
                    $display("[TB] FAIL reparam write %0d cycle %0d: ctl/lat_d got %b/%h expected %b/%h",
                             i, n, obs_ctl[n], obs_d[n], e, d);
                end
            end
            tests_run++;
            if (obs_cnt[T2] !== 8'(model_cnt2)) begin
                tests_failed++;
                $display("[TB] FAIL reparam err_count: got %0d expected %0d", obs_cnt[T2], model_cnt2);
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b1;
        sel       = 1'b0;
        stuck     = 1'b0;
        in_valid1 = 1'b0;
        in_data1  = 8'h00;
        in_valid2 = 1'b0;
        in_data2  = 8'h00;
        #1;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_stuck_latch();
        test_saturation();
        test_reset();
        test_random_writes();
        test_reparam();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
